// File: rtl/jtframe_pocket_vidfmt_if.sv
// rtl/jtframe_pocket_vidfmt_if.sv - core video in / Pocket APF video out bundle
interface jtframe_pocket_vidfmt_if #(
    parameter int COLORW = 4
);
    logic                  pxl2_cen;
    logic                  pattern;
    logic [3*COLORW-1:0]   base_rgb;
    logic                  base_LHBL;
    logic                  base_LVBL;
    logic                  base_hs;
    logic                  base_vs;
    logic [23:0]           pck_rgb;
    logic                  pck_rgb_clk;
    logic                  pck_rgb_clkq;
    logic                  pck_de;
    logic                  pck_skip;
    logic                  pck_hs;
    logic                  pck_vs;
    logic [11:0]           hactive;
    logic [11:0]           vactive;
    logic                  frame_ok;

    modport master (
        output pxl2_cen, pattern, base_rgb, base_LHBL, base_LVBL, base_hs, base_vs,
        input  pck_rgb, pck_rgb_clk, pck_rgb_clkq, pck_de, pck_skip, pck_hs, pck_vs,
        input  hactive, vactive, frame_ok
    );

    modport slave (
        input  pxl2_cen, pattern, base_rgb, base_LHBL, base_LVBL, base_hs, base_vs,
        output pck_rgb, pck_rgb_clk, pck_rgb_clkq, pck_de, pck_skip, pck_hs, pck_vs,
        output hactive, vactive, frame_ok
    );
endinterface

// File: rtl/jtframe_pocket_vidfmt.sv
// rtl/jtframe_pocket_vidfmt.sv - Pocket scaler video formatter with frame size measurement
module jtframe_pocket_vidfmt #(
    parameter int COLORW = 4,
    parameter int HS_DLY = 0,
    parameter int HDIV   = 1,
    parameter int BAR_SH = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    jtframe_pocket_vidfmt_if.slave  vid
);
    logic              r_clk, r_clkq, r_hit;
    logic [3:0]        r_per, r_prd;
    logic              r_hsl, r_vsl, r_de, r_skip, r_vs_prev, r_frame_ok;
    logic [HS_DLY:0]   r_hsh, r_vsh;
    logic [23:0]       r_rgb;
    logic [11:0]       r_hcnt, r_hlast, r_vcnt, r_hactive, r_vactive;

    logic              w_s, w_de, w_hs_edge, w_vs_edge;
    logic [2:0]        w_bar;
    logic [23:0]       w_rgb;

    function automatic logic [7:0] ext8(input logic [COLORW-1:0] a);
        logic [3*COLORW-1:0] t;
        t = {a, a, a};
        return t[3*COLORW-1 -: 8];
    endfunction

    assign w_s       = vid.pxl2_cen & ~r_clk;
    assign w_de      = vid.base_LHBL & vid.base_LVBL;
    assign w_hs_edge = vid.base_hs & ~r_hsl;
    assign w_vs_edge = vid.base_vs & ~r_vsl;
    assign w_bar     = r_hcnt[BAR_SH+2:BAR_SH];
    assign w_rgb     = vid.pattern ? {{8{w_bar[2]}}, {8{w_bar[1]}}, {8{w_bar[0]}}}
                                   : {ext8(vid.base_rgb[3*COLORW-1 -: COLORW]),
                                      ext8(vid.base_rgb[2*COLORW-1 -: COLORW]),
                                      ext8(vid.base_rgb[COLORW-1:0])};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk      <= 1'b0;
            r_clkq     <= 1'b0;
            r_hit      <= 1'b0;
            r_per      <= 4'd0;
            r_prd      <= 4'd0;
            r_hsl      <= 1'b0;
            r_vsl      <= 1'b0;
            r_hsh      <= '0;
            r_vsh      <= '0;
            r_de       <= 1'b0;
            r_skip     <= 1'b0;
            r_rgb      <= 24'd0;
            r_hcnt     <= 12'd0;
            r_hlast    <= 12'd0;
            r_vcnt     <= 12'd0;
            r_hactive  <= 12'd0;
            r_vactive  <= 12'd0;
            r_frame_ok <= 1'b0;
            r_vs_prev  <= 1'b0;
        end else begin
            if (vid.pxl2_cen) begin
                r_clk <= ~r_clk;
                r_per <= 4'd0;
                r_prd <= r_per;
            end else if (r_per != 4'hf) begin
                r_per <= r_per + 4'd1;
            end
            // The match is registered once more so clkq trails by half a cen period
            r_hit <= (r_per == (r_prd >> 1) - 4'd1);
            if (r_prd < 4'd2 || r_hit)
                r_clkq <= r_clk;

            if (w_s) begin
                r_hsl     <= vid.base_hs;
                r_vsl     <= vid.base_vs;
                r_hsh[0]  <= w_hs_edge;
                r_vsh[0]  <= w_vs_edge;
                for (int i = 1; i <= HS_DLY; i++) begin
                    r_hsh[i] <= r_hsh[i-1];
                    r_vsh[i] <= r_vsh[i-1];
                end
                r_de   <= w_de;
                r_rgb  <= w_de ? w_rgb : 24'd0;
                r_skip <= (HDIV == 2) ? (w_de & r_hcnt[0]) : 1'b0;
                if (!w_de)
                    r_hcnt <= 12'd0;
                else if (r_hcnt != 12'hfff)
                    r_hcnt <= r_hcnt + 12'd1;
                if (r_de && !w_de) begin
                    r_hlast <= r_hcnt;
                    if (r_vcnt != 12'hfff)
                        r_vcnt <= r_vcnt + 12'd1;
                end
            end

            // Runs the clk after the S that raised pck_vs, never on an S cycle
            r_vs_prev <= r_vsh[HS_DLY];
            if (r_vsh[HS_DLY] && !r_vs_prev) begin
                r_hactive  <= r_hlast;
                r_vactive  <= r_vcnt;
                r_vcnt     <= 12'd0;
                r_frame_ok <= (r_hlast == r_hactive) && (r_vcnt == r_vactive);
            end
        end
    end

    assign vid.pck_rgb      = r_rgb;
    assign vid.pck_rgb_clk  = r_clk;
    assign vid.pck_rgb_clkq = r_clkq;
    assign vid.pck_de       = r_de;
    assign vid.pck_skip     = r_skip;
    assign vid.pck_hs       = r_hsh[HS_DLY];
    assign vid.pck_vs       = r_vsh[HS_DLY];
    assign vid.hactive      = r_hactive;
    assign vid.vactive      = r_vactive;
    assign vid.frame_ok     = r_frame_ok;
endmodule
